parity_checker: RTL
===================

Name: parity_checker

Overview:
- Receive-side counterpart of the byte parity generator: accepts data words with an attached parity bit, checks parity, and forwards the data with a per-word error flag.
- Sits at the consumer end of any link that carries generator-protected bytes; it is placed between the link and the downstream sink.
- Uses a valid/ready handshake on both sides, a one-cycle registered output stage with a skid buffer for full throughput, a sticky error flag, and an optional saturating error counter.

Parameters:
- DATA_WIDTH, 8, data bits per word, excluding the parity bit.
- ODD_PARITY, 0, 0 means even parity (XOR of data and parity must be 0); 1 means odd parity (XOR must be 1).
- CNT_WIDTH, 8, width of the error counter; only used when the optional feature is compiled in.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  received data.
- in_parity  input  1  received parity bit.
- in_valid  input  1  in_data and in_parity are valid.
- in_ready  output  1  block can accept a word this cycle; driven directly from a register.
- out_data  output  DATA_WIDTH  forwarded data.
- out_error  output  1  parity mismatch for the word on out_data.
- out_valid  output  1  out_data and out_error are valid.
- out_ready  input  1  sink accepts the output word.
- err_sticky  output  1  set by any accepted bad word; cleared only by clr_err or rst.
- clr_err  input  1  one-cycle pulse that clears err_sticky and the error counter.

Behaviour:
- Transfers: an input transfer happens when in_valid && in_ready; an output transfer happens when out_valid && out_ready.
- Error check: err = (^in_data ^ in_parity) != ODD_PARITY. It is evaluated at the input transfer and stored with the word.
- Storage: one main output register plus one skid entry.
- in_ready = !skid_valid. It is registered, with no combinational path from out_ready.
- Latency: a word accepted in cycle N appears on out_* in cycle N+1 when the output register is empty or is draining in cycle N.
- Input accepted, output register empty or draining: the word loads the output register.
- Input accepted, output register full and stalled: the word loads the skid entry, and in_ready drops in the next cycle.
- Output transfer while skid is valid: the skid word moves to the output register and in_ready rises in the next cycle.
- Order is strictly preserved. Words are never dropped or duplicated, and a bad word is forwarded with out_error=1.
- Throughput: one word per cycle while out_ready stays high.
- out_data, out_error and out_valid hold stable while out_valid && !out_ready.
- Sticky flag, on an accepted bad word: err_sticky is set in the next cycle.
- Sticky flag, clr_err alone: err_sticky is 0 in the next cycle.
- Sticky flag, clr_err together with an accepted bad word: the new error wins, so err_sticky=1 and counter=1.
- Reset values: out_valid=0, out_error=0, out_data=0, skid_valid=0, in_ready=1, err_sticky=0, counter=0.
- Reset mid-operation: all buffered words are discarded, with no partial output afterwards. in_ready is 1 in the first cycle after rst deasserts.
- Words presented while rst=1 are not accepted.

Optional Feature:
- Macro: PARITY_CHECKER_ERR_CNT_EN.
- When defined: an extra output err_count (output, CNT_WIDTH) is present.
  - It increments by 1 on each accepted bad word and saturates at 2^CNT_WIDTH-1, never wrapping.
  - clr_err resets it to 0; with a simultaneous bad word it becomes 1.
  - Reset value is 0.
- When undefined: the err_count port and counter logic do not exist; all other behaviour is identical.

Test Plan:
- Even parity, out_ready=1: send 0xA5/p=0, 0x01/p=1, 0x01/p=0 back-to-back. Required: outputs at cycles +1..+3 with out_error 0,0,1; err_sticky=1 after the third word; err_count=1.
- ODD_PARITY=1: send 0x00/p=1, then 0x00/p=0. Required: out_error 0, then 1.
- Backpressure: out_ready=0 with three words offered. Required: the first word is held in the output register, the second in the skid entry, in_ready=0 from the next cycle, and the third is not accepted. Raise out_ready: all three words emerge in order with no gaps after the first.
- Clear: err_sticky=1 and err_count=5; pulse clr_err alone, giving sticky=0 and count=0. Then clr_err in the same cycle as a bad word gives sticky=1 and count=1.
- Saturation, CNT_WIDTH=2: send 5 bad words. Required: err_count sequence 1,2,3,3,3.
- Reset mid-stream: assert rst for 1 cycle with both output and skid entries full. Required: out_valid=0 and in_ready=1 next cycle; err_sticky=0 and count=0; no stale word is ever emitted.

Source files
------------

// File: rtl/parity_checker_if.sv
// Valid/ready bundle for the parity checker: parity-tagged words in,
// checked words with an error flag out.
interface parity_checker_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_parity;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_error;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_parity, in_valid, out_ready,
      input  in_ready, out_data, out_error, out_valid
   );

   modport slave (
      input  in_data, in_parity, in_valid, out_ready,
      output in_ready, out_data, out_error, out_valid
   );
endinterface

// File: rtl/parity_checker.sv
// Receive-side parity check with a registered output stage, one skid
// entry and a sticky error flag; PARITY_CHECKER_ERR_CNT_EN adds err_count.
module parity_checker #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          ODD_PARITY = 1'b0,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic             clk,
   input  logic             rst,
   parity_checker_if.slave  bus,
   output logic             err_sticky,
   input  logic             clr_err
`ifdef PARITY_CHECKER_ERR_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] err_count
`endif
);

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_error_q, out_error_d;
   logic                  skid_valid_q, skid_valid_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic                  skid_error_q, skid_error_d;
   logic                  in_ready_q, in_ready_d;
   logic                  err_sticky_q, err_sticky_d;

   logic in_fire;
   logic in_err;
   logic out_stall;
   logic bad_fire;

   always_comb begin
      in_fire   = bus.in_valid && in_ready_q;
      in_err    = ((^bus.in_data) ^ bus.in_parity) != ODD_PARITY;
      out_stall = out_valid_q && !bus.out_ready;
      bad_fire  = in_fire && in_err;
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_error_d  = out_error_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_error_d = skid_error_q;

      // in_ready_q mirrors !skid_valid_q, so no input fires while skid holds a word
      if (skid_valid_q) begin
         if (!out_stall) begin
            out_data_d   = skid_data_q;
            out_error_d  = skid_error_q;
            skid_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         if (out_stall) begin
            skid_data_d  = bus.in_data;
            skid_error_d = in_err;
            skid_valid_d = 1'b1;
         end else begin
            out_data_d  = bus.in_data;
            out_error_d = in_err;
            out_valid_d = 1'b1;
         end
      end else if (!out_stall) begin
         out_valid_d = 1'b0;
      end

      in_ready_d = !skid_valid_d;
   end

   // a new error in the same cycle as a clear takes priority
   always_comb begin
      err_sticky_d = bad_fire || (err_sticky_q && !clr_err);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_error_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_error_q <= 1'b0;
         in_ready_q   <= 1'b1;
         err_sticky_q <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_error_q  <= out_error_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_error_q <= skid_error_d;
         in_ready_q   <= in_ready_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_error = out_error_q;
   assign err_sticky    = err_sticky_q;

`ifdef PARITY_CHECKER_ERR_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (clr_err) begin
         err_count_d = bad_fire ? CNT_WIDTH'(1) : '0;
      end else if (bad_fire && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;
`else
   // counter absent; the width is still validated so both builds accept the same parameters
   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("CNT_WIDTH must be at least 1");
   end
`endif

endmodule
